// File: rtl/operand_stack.sv
// Responder side of the control unit's stack push/pop handshake.
// The LIFO lives in a synchronous RAM, and each request completes with a one-cycle done_out pulse.
module operand_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     trigger,
    input  logic [WIDTH-1:0]         write_value,
    output logic [WIDTH-1:0]         read_value,
    output logic                     done_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               op_push;
    logic [WIDTH-1:0]   wdata;
    logic [CNT_W-1:0]   sp;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic               full;
    logic               empty;
    logic [PTR_W-1:0]   wr_idx;
    logic [PTR_W-1:0]   rd_idx;

    logic               latch_req;
    logic               finish;
    logic               mem_we;
    logic               mem_re;
    logic               set_ovf;
    logic               set_unf;

    assign full   = (sp == CNT_W'(DEPTH));
    assign empty  = (sp == '0);
    assign wr_idx = sp[PTR_W-1:0];
    assign rd_idx = PTR_W'(sp - CNT_W'(1));
    assign count  = sp;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: trigger only matters in IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state datapath controls; full/empty checks turn illegal ops into flag updates
    always_comb begin
        latch_req = 1'b0;
        finish    = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        case (state)
            IDLE: latch_req = trigger;
            EXEC: begin
                finish = 1'b1;
                if (op_push) begin
                    if (full) set_ovf = 1'b1;
                    else      mem_we  = 1'b1;
                end else begin
                    if (empty) set_unf = 1'b1;
                    else       mem_re  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Request latch, stack pointer, response and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_push    <= 1'b0;
            wdata      <= '0;
            sp         <= '0;
            read_value <= '0;
            done_out   <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            done_out <= finish;
            if (latch_req) begin
                op_push <= push;
                wdata   <= write_value;
            end
            if (mem_we) begin
                sp <= sp + CNT_W'(1);
            end
            if (mem_re) begin
                read_value <= mem[rd_idx];
                sp         <= sp - CNT_W'(1);
            end
            if (set_unf) begin
                read_value <= '0;
                underflow  <= 1'b1;
            end
            if (set_ovf) begin
                overflow <= 1'b1;
            end
        end
    end

    // RAM is not cleared by reset, but a reset landing on EXEC must suppress the write
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: a DEPTH=256 and a DEPTH=4 instance share one stimulus stream.
// The bench checks both instances against queue-based LIFO models.
module tb_operand_stack;

    localparam int DEPTH_A = 256;
    localparam int DEPTH_B = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic        trigger;
    logic [31:0] write_value;

    logic [31:0] rv_a, rv_b;
    logic        done_a, done_b;
    logic [8:0]  cnt_a;
    logic [2:0]  cnt_b;
    logic        ovf_a, unf_a, ovf_b, unf_b;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic        m_ovf_a, m_unf_a, m_ovf_b, m_unf_b;
    logic [31:0] m_rv_a, m_rv_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    operand_stack #(.WIDTH(32), .DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .push(push), .trigger(trigger),
        .write_value(write_value), .read_value(rv_a), .done_out(done_a),
        .count(cnt_a), .overflow(ovf_a), .underflow(unf_a)
    );

    operand_stack #(.WIDTH(32), .DEPTH(DEPTH_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .push(push), .trigger(trigger),
        .write_value(write_value), .read_value(rv_b), .done_out(done_b),
        .count(cnt_b), .overflow(ovf_b), .underflow(unf_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        q_a.delete();
        q_b.delete();
        m_ovf_a = 1'b0; m_unf_a = 1'b0; m_rv_a = '0;
        m_ovf_b = 1'b0; m_unf_b = 1'b0; m_rv_b = '0;
    endfunction

    // LIFO semantics: full push sets overflow, empty pop yields 0 and sets underflow
    function automatic void model_op(input logic p, input logic [31:0] v);
        if (p) begin
            if (q_a.size() < DEPTH_A) q_a.push_back(v); else m_ovf_a = 1'b1;
            if (q_b.size() < DEPTH_B) q_b.push_back(v); else m_ovf_b = 1'b1;
        end else begin
            if (q_a.size() > 0) m_rv_a = q_a.pop_back(); else begin m_rv_a = '0; m_unf_a = 1'b1; end
            if (q_b.size() > 0) m_rv_b = q_b.pop_back(); else begin m_rv_b = '0; m_unf_b = 1'b1; end
        end
    endfunction

    task automatic do_reset();
        trigger = 1'b0;
        rst_n   = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    // One request, then two idle cycles; reports whether done_out rose only after edge N+1
    task automatic do_op(input logic p, input logic [31:0] v, output bit lat_ok,
                         output logic [31:0] rvd_a, output logic [31:0] rvd_b);
        push = p; write_value = v; trigger = 1'b1;
        tick();
        lat_ok = !done_a && !done_b;
        trigger = 1'b0; push = 1'($urandom); write_value = $urandom;
        tick();
        lat_ok = lat_ok && done_a && done_b;
        rvd_a = rv_a; rvd_b = rv_b;
        tick();
        lat_ok = lat_ok && !done_a && !done_b;
        model_op(p, v);
    endtask

    // Initiator-style op: pulse trigger, wait for done_out, then return one cycle later
    task automatic hs_op(input logic p, input logic [31:0] v, output bit ok, output logic [31:0] rv);
        push = p; write_value = v; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        ok = 1'b0; rv = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done_a) begin ok = 1'b1; rv = rv_a; break; end
        end
        tick();
        model_op(p, v);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trigger = 1'b0; push = 1'b0; write_value = '0;
        tick(); tick();
        compared++;
        if ({done_a, cnt_a, ovf_a, unf_a, rv_a} !== '0) begin
            mismatched++;
            $display("FAIL reset_a: got done=%b cnt=%0d ovf=%b unf=%b rv=%h required all zero", done_a, cnt_a, ovf_a, unf_a, rv_a);
        end
        compared++;
        if ({done_b, cnt_b, ovf_b, unf_b, rv_b} !== '0) begin
            mismatched++;
            $display("FAIL reset_b: got done=%b cnt=%0d ovf=%b unf=%b rv=%h required all zero", done_b, cnt_b, ovf_b, unf_b, rv_b);
        end
        rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic test_push_pop();
        bit lat;
        logic [31:0] ra, rb;
        logic        ops  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] vals [4] = '{32'h5, 32'h7, 32'h0, 32'h0};
        logic [31:0] exp_rv [4] = '{32'h0, 32'h0, 32'h7, 32'h5};
        int          exp_cnt [4] = '{1, 2, 1, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], vals[i], lat, ra, rb);
            compared++;
            if (!lat) begin
                mismatched++;
                $display("FAIL push_pop_latency op%0d: done_out pulse not exactly at edge N+1", i);
            end
            compared++;
            if (cnt_a !== 9'(exp_cnt[i]) || ra !== exp_rv[i]) begin
                mismatched++;
                $display("FAIL push_pop op%0d: got cnt=%0d rv=%h required cnt=%0d rv=%h", i, cnt_a, ra, exp_cnt[i], exp_rv[i]);
            end
        end
    endtask

    task automatic test_underflow();
        bit lat;
        logic [31:0] ra, rb;
        do_reset();
        do_op(1'b0, 32'hDEAD_BEEF, lat, ra, rb);
        compared++;
        if (!lat || ra !== 32'h0 || unf_a !== 1'b1 || cnt_a !== 9'd0 || ovf_a !== 1'b0) begin
            mismatched++;
            $display("FAIL underflow_pop: got lat=%b rv=%h unf=%b cnt=%0d ovf=%b required 1 0 1 0 0", lat, ra, unf_a, cnt_a, ovf_a);
        end
        do_op(1'b1, 32'h9, lat, ra, rb);
        do_op(1'b0, 32'h0, lat, ra, rb);
        compared++;
        if (ra !== 32'h9 || unf_a !== 1'b1 || unf_b !== 1'b1 || cnt_a !== 9'd0) begin
            mismatched++;
            $display("FAIL underflow_sticky: got rv=%h unf_a=%b unf_b=%b cnt=%0d required 9 1 1 0", ra, unf_a, unf_b, cnt_a);
        end
    endtask

    task automatic test_overflow();
        bit lat;
        logic [31:0] ra, rb;
        do_reset();
        for (int i = 1; i <= 5; i++) do_op(1'b1, 32'(i), lat, ra, rb);
        compared++;
        if (cnt_b !== 3'd4 || ovf_b !== 1'b1 || cnt_a !== 9'd5 || ovf_a !== 1'b0) begin
            mismatched++;
            $display("FAIL overflow_full: got cnt_b=%0d ovf_b=%b cnt_a=%0d ovf_a=%b required 4 1 5 0", cnt_b, ovf_b, cnt_a, ovf_a);
        end
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, 32'h0, lat, ra, rb);
            compared++;
            if (!lat || rb !== 32'(4 - i) || ra !== 32'(5 - i)) begin
                mismatched++;
                $display("FAIL overflow_pop%0d: got lat=%b rv_b=%h rv_a=%h required 1 %h %h", i, lat, rb, ra, 4 - i, 5 - i);
            end
        end
        compared++;
        if (cnt_b !== 3'd0 || ovf_b !== 1'b1 || unf_b !== 1'b0) begin
            mismatched++;
            $display("FAIL overflow_sticky: got cnt_b=%0d ovf_b=%b unf_b=%b required 0 1 0", cnt_b, ovf_b, unf_b);
        end
    endtask

    task automatic test_held_trigger();
        bit lat;
        logic [31:0] ra, rb;
        logic [31:0] vals [9];
        logic [8:0]  done_mask;
        foreach (vals[i]) vals[i] = $urandom;
        do_reset();
        done_mask = '0;
        trigger = 1'b1; push = 1'b1;
        for (int i = 0; i < 9; i++) begin
            write_value = vals[i];
            tick();
            done_mask[i] = done_a;
        end
        trigger = 1'b0;
        tick(); tick();
        compared++;
        if (done_mask !== 9'b010010010 || cnt_a !== 9'd3) begin
            mismatched++;
            $display("FAIL held_trigger: got done_mask=%b cnt=%0d required 010010010 3", done_mask, cnt_a);
        end
        model_op(1'b1, vals[0]); model_op(1'b1, vals[3]); model_op(1'b1, vals[6]);
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, 32'h0, lat, ra, rb);
            compared++;
            if (ra !== m_rv_a || rb !== m_rv_b) begin
                mismatched++;
                $display("FAIL held_trigger_pop%0d: got rv_a=%h rv_b=%h required %h %h", i, ra, rb, m_rv_a, m_rv_b);
            end
        end
    endtask

    task automatic test_handshake();
        bit lat, ok1, ok2, ok3;
        logic [31:0] ra, rb, x, y, z;
        do_reset();
        do_op(1'b1, 32'h3, lat, ra, rb);
        do_op(1'b1, 32'h4, lat, ra, rb);
        hs_op(1'b0, 32'h0, ok1, x);
        hs_op(1'b0, 32'h0, ok2, y);
        hs_op(1'b1, x + y, ok3, z);
        compared++;
        if (!(ok1 && ok2 && ok3) || x !== 32'h4 || y !== 32'h3 || cnt_a !== 9'd1) begin
            mismatched++;
            $display("FAIL handshake_alu: got ok=%b%b%b x=%h y=%h cnt=%0d required 111 4 3 1", ok1, ok2, ok3, x, y, cnt_a);
        end
        hs_op(1'b0, 32'h0, ok1, z);
        compared++;
        if (!ok1 || z !== 32'h7 || cnt_a !== 9'd0) begin
            mismatched++;
            $display("FAIL handshake_sum: got ok=%b rv=%h cnt=%0d required 1 7 0", ok1, z, cnt_a);
        end
    endtask

    task automatic test_reset_abort();
        bit lat;
        logic [31:0] ra, rb;
        do_reset();
        push = 1'b1; write_value = $urandom; trigger = 1'b1;
        tick();
        trigger = 1'b0; rst_n = 1'b0;
        tick();
        compared++;
        if ({done_a, cnt_a, ovf_a, unf_a} !== '0) begin
            mismatched++;
            $display("FAIL reset_abort: got done=%b cnt=%0d ovf=%b unf=%b required 0 0 0 0", done_a, cnt_a, ovf_a, unf_a);
        end
        rst_n = 1'b1;
        tick();
        compared++;
        if (done_a !== 1'b0 || cnt_a !== 9'd0) begin
            mismatched++;
            $display("FAIL reset_abort_after: got done=%b cnt=%0d required 0 0", done_a, cnt_a);
        end
        model_reset();
        do_op(1'b0, 32'h0, lat, ra, rb);
        compared++;
        if (!lat || ra !== 32'h0 || unf_a !== 1'b1 || cnt_a !== 9'd0) begin
            mismatched++;
            $display("FAIL reset_abort_pop: got lat=%b rv=%h unf=%b cnt=%0d required 1 0 1 0", lat, ra, unf_a, cnt_a);
        end
    endtask

    task automatic test_random();
        bit lat;
        logic p;
        logic [31:0] v, ra, rb;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            p = ($urandom_range(0, 9) < 6);
            v = $urandom;
            do_op(p, v, lat, ra, rb);
            compared++;
            if (!lat || {cnt_a, ovf_a, unf_a, ra} !== {9'(q_a.size()), m_ovf_a, m_unf_a, m_rv_a}) begin
                mismatched++;
                $display("FAIL random_a op%0d: got lat=%b cnt=%0d ovf=%b unf=%b rv=%h required 1 %0d %b %b %h",
                         i, lat, cnt_a, ovf_a, unf_a, ra, q_a.size(), m_ovf_a, m_unf_a, m_rv_a);
            end
            compared++;
            if ({cnt_b, ovf_b, unf_b, rb} !== {3'(q_b.size()), m_ovf_b, m_unf_b, m_rv_b}) begin
                mismatched++;
                $display("FAIL random_b op%0d: got cnt=%0d ovf=%b unf=%b rv=%h required %0d %b %b %h",
                         i, cnt_b, ovf_b, unf_b, rb, q_b.size(), m_ovf_b, m_unf_b, m_rv_b);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_push_pop();
        test_underflow();
        test_overflow();
        test_held_trigger();
        test_handshake();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
